// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: scans the full raster, requests half-resolution game
// pixels from the renderer and registers colour, syncs and data-enable in alignment.
module vga_scan_driver #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_SHIFT   = 1,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic [15:0] pixel_rgb,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_tick
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CRD_W   = 9;
  localparam int unsigned RGB_W   = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_TICK   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [RGB_W-1:0] vga_rgb_q;
  logic             vga_hs_q, vga_vs_q, vga_de_q, frame_tick_q;
  logic             active_c, hs_on_c, vs_on_c, tick_c;

  // Raster position decode from the current (pre-increment) counters
  always_comb begin
    active_c = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_on_c  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_on_c  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    tick_c   = pix_ce && (h_cnt_q == H_LAST) && (v_cnt_q == V_TICK);
  end

  assign pixel_x = active_c ? CRD_W'(h_cnt_q >> PIX_SHIFT) : '0;
  assign pixel_y = active_c ? CRD_W'(v_cnt_q >> PIX_SHIFT) : '0;

  // Counter advance, one raster pixel per enable
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      vga_rgb_q    <= '0;
      vga_de_q     <= 1'b0;
      vga_hs_q     <= ~SYNC_ACTIVE;
      vga_vs_q     <= ~SYNC_ACTIVE;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= tick_c;
      if (pix_ce) begin
        vga_rgb_q <= active_c ? pixel_rgb : '0;
        vga_de_q  <= active_c;
        vga_hs_q  <= hs_on_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga_vs_q  <= vs_on_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
    end
  end

  assign vga_rgb    = vga_rgb_q;
  assign vga_hs     = vga_hs_q;
  assign vga_vs     = vga_vs_q;
  assign vga_de     = vga_de_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench: full-size raster for line timing, a shrunken raster for frame timing.
module tb_vga_scan_driver;

  typedef struct packed {
    logic [15:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        tick;
  } exp_t;

  localparam int HA[2] = '{640, 8};
  localparam int HF[2] = '{16, 2};
  localparam int HS[2] = '{96, 3};
  localparam int HB[2] = '{48, 3};
  localparam int VA[2] = '{480, 6};
  localparam int VF[2] = '{10, 1};
  localparam int VS[2] = '{2, 2};
  localparam int VB[2] = '{33, 1};

  localparam exp_t RST_EXP = '{rgb: 16'h0, de: 1'b0, hs: 1'b1, vs: 1'b1, tick: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic [8:0]  px[2], py[2];
  logic [15:0] rgb_in[2], vrgb[2];
  logic        hs[2], vs[2], de[2], tick[2];
  logic        ce_s;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   hm[2], vm[2];
  exp_t q0[$], q1[$];
  exp_t last_e[2];
  exp_t got, e;
  int   idx[2];
  int   first_hs, hs_low, de0, rgb640, rgb641;
  int   vs_low, de1, ticks, first_tick, r88, r89;

  always #5 clk = ~clk;

  assign rgb_in[0] = {py[0][6:0], px[0]};
  assign rgb_in[1] = {py[1][6:0], px[1]};

  vga_scan_driver u_full (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pixel_rgb(rgb_in[0]),
    .pixel_x(px[0]), .pixel_y(py[0]), .vga_rgb(vrgb[0]), .vga_hs(hs[0]),
    .vga_vs(vs[0]), .vga_de(de[0]), .frame_tick(tick[0])
  );

  vga_scan_driver #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pixel_rgb(rgb_in[1]),
    .pixel_x(px[1]), .pixel_y(py[1]), .vga_rgb(vrgb[1]), .vga_hs(hs[1]),
    .vga_vs(vs[1]), .vga_de(de[1]), .frame_tick(tick[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int i, input int h, input int v);
    exp_t r;
    logic act;
    act    = (h < HA[i]) && (v < VA[i]);
    r.rgb  = act ? {7'(v >> 1), 9'(h >> 1)} : 16'h0;
    r.de   = act;
    r.hs   = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
    r.vs   = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
    r.tick = (h == HA[i] + HF[i] + HS[i] + HB[i] - 1) && (v == VA[i] - 1);
    return r;
  endfunction

  function automatic logic [8:0] exp_coord(input int i, input int c, input int h, input int v);
    if ((h < HA[i]) && (v < VA[i])) return 9'(c >> 1);
    return 9'd0;
  endfunction

  task automatic clear_all();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      hm[i] = 0; vm[i] = 0; idx[i] = 0; last_e[i] = RST_EXP;
    end
    first_hs = 0; hs_low = 0; de0 = 0; rgb640 = -1; rgb641 = -1;
    vs_low = 0; de1 = 0; ticks = 0; first_tick = 0; r88 = -1; r89 = -1;
  endtask

  // Called just after a clock edge: checks requested coords, then queues the expected output
  task automatic drive(input logic ce);
    pix_ce = ce;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pixel_x[%0d]", i), 32'(px[i]), 32'(exp_coord(i, hm[i], hm[i], vm[i])));
      chk($sformatf("pixel_y[%0d]", i), 32'(py[i]), 32'(exp_coord(i, vm[i], hm[i], vm[i])));
      if (ce) begin
        if (i == 0) q0.push_back(model(0, hm[0], vm[0]));
        else        q1.push_back(model(1, hm[1], vm[1]));
        if (hm[i] == HA[i] + HF[i] + HS[i] + HB[i] - 1) begin
          hm[i] = 0;
          vm[i] = (vm[i] == VA[i] + VF[i] + VS[i] + VB[i] - 1) ? 0 : vm[i] + 1;
        end else begin
          hm[i] = hm[i] + 1;
        end
      end
    end
  endtask

  task automatic step(input logic ce);
    @(posedge clk);
    #1;
    drive(ce);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ce_s <= 1'b0;
    else        ce_s <= pix_ce;
  end

  // Monitor: every enabled edge must match the queued expectation, idle edges must hold
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        got = {vrgb[i], de[i], hs[i], vs[i], tick[i]};
        if (ce_s) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty[%0d]: output seen with no expectation queued", i);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("scoreboard[%0d] idx %0d", i, idx[i] + 1), 32'(got), 32'(e));
            last_e[i]      = e;
            last_e[i].tick = 1'b0;
            idx[i]++;
            if (i == 0 && idx[0] <= 800) begin
              if (!got.hs) begin
                hs_low++;
                if (first_hs == 0) first_hs = idx[0];
              end
              if (got.de) de0++;
              if (idx[0] == 640) rgb640 = int'(got.rgb);
              if (idx[0] == 641) rgb641 = int'(got.rgb);
            end
            if (i == 1) begin
              if (idx[1] <= 160) begin
                if (!got.vs) vs_low++;
                if (got.de) de1++;
              end
              if (idx[1] <= 320 && got.tick) begin
                ticks++;
                if (first_tick == 0) first_tick = idx[1];
              end
              if (idx[1] == 88) r88 = int'(got.rgb);
              if (idx[1] == 89) r89 = int'(got.rgb);
            end
          end
        end else begin
          chk($sformatf("hold[%0d]", i), 32'(got), 32'(last_e[i]));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_out[%0d]", tag, i), 32'({vrgb[i], de[i], hs[i], vs[i], tick[i]}), 32'(RST_EXP));
      chk($sformatf("%s_pixel_x[%0d]", tag, i), 32'(px[i]), 32'd0);
    end
  endtask

  task automatic chk_line_stats(input string tag);
    chk({tag, "_first_hs_low_idx"}, 32'(first_hs), 32'd657);
    chk({tag, "_hs_low_count"}, 32'(hs_low), 32'd96);
    chk({tag, "_de_count"}, 32'(de0), 32'd640);
  endtask

  initial begin
    clear_all();
    rst_n  = 1'b0;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");

    // Release with pix_ce already high; first enabled edge shows raster (0,0)
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1);
    repeat (1700) step(1'b1);
    step(1'b0);
    chk_line_stats("line0");
    chk("rgb_639_0", 32'(rgb640), 32'h013F);
    chk("rgb_640_0", 32'(rgb641), 32'h0);
    chk("small_vs_low", 32'(vs_low), 32'd32);
    chk("small_de_frame", 32'(de1), 32'd48);
    chk("small_ticks_2frames", 32'(ticks), 32'd2);
    chk("small_first_tick_idx", 32'(first_tick), 32'd96);
    chk("small_rgb_7_5", 32'(r88), 32'h0403);
    chk("small_rgb_8_5", 32'(r89), 32'h0);

    // Sparse enables: one pix_ce every 4th clock, holds checked in between
    for (int k = 0; k < 200; k++) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end

    // Asynchronous reset mid-line at raster (300,y)
    while (hm[0] != 300) step(1'b1);
    @(posedge clk);
    #2;
    pix_ce = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    drive(1'b1);
    repeat (820) step(1'b1);
    step(1'b0);
    chk_line_stats("after_reset");

    step(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
